// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// Immediate generator feeding a 2-entry FIFO of {imm, tag, err} entries.
// Latency: an entry pushed at edge N is presented on out_valid in the cycle after edge N.
// Backpressure: out_accept drops only when both slots are full; it comes from registered occupancy only.
module imm_gen_pipe #(
    parameter int XLEN        = 64,
    parameter int AUTO_DECODE = 0,
    parameter int TAG_W       = 5
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic [2:0]       in_inst_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_accept,
    input  logic             in_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [15:0]      out_err_count
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_BAD  = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    logic [2:0]       fmt;
    logic [31:0]      imm32;
    logic [63:0]      imm64;
    logic [XLEN-1:0]  imm_new;
    logic             err_new;

    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       err_q;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             push, pop;

    // Select the immediate format: explicit type input, or derived from the opcode field.
    always_comb begin
        fmt = in_inst_type;
        if (AUTO_DECODE != 0) begin
            case (in_data[6:0])
                7'b0000011, 7'b0010011, 7'b0011011,
                7'b1100111, 7'b1110011:             fmt = FMT_I;
                7'b0100011:                         fmt = FMT_S;
                7'b1100011:                         fmt = FMT_B;
                7'b0110111, 7'b0010111:             fmt = FMT_U;
                7'b1101111:                         fmt = FMT_J;
                7'b0110011, 7'b0111011:             fmt = FMT_NONE;
                default:                            fmt = FMT_BAD;
            endcase
        end
    end

    // Assemble the 32-bit sign-extended immediate; unknown formats yield zero with err set.
    always_comb begin
        imm32   = '0;
        err_new = 1'b0;
        case (fmt)
            FMT_I:    imm32 = {{20{in_data[31]}}, in_data[31:20]};
            FMT_S:    imm32 = {{20{in_data[31]}}, in_data[31:25], in_data[11:7]};
            FMT_B:    imm32 = {{19{in_data[31]}}, in_data[31], in_data[7],
                               in_data[30:25], in_data[11:8], 1'b0};
            FMT_U:    imm32 = {in_data[31:12], 12'b0};
            FMT_J:    imm32 = {{11{in_data[31]}}, in_data[31], in_data[19:12],
                               in_data[20], in_data[30:21], 1'b0};
            FMT_NONE: imm32 = '0;
            default:  err_new = 1'b1;
        endcase
    end

    // Every format already carries in_data[31] in bit 31, so widening just replicates it.
    assign imm64   = {{32{imm32[31]}}, imm32};
    assign imm_new = imm64[XLEN-1:0];

    assign out_accept = (occ_q != 2'd2);
    assign out_valid  = (occ_q != 2'd0);
    assign push       = in_valid & out_accept;
    assign pop        = out_valid & in_ready;

    assign out_data      = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_tag       = out_valid ? tag_q[rd_ptr_q] : '0;
    assign out_err       = out_valid ? err_q[rd_ptr_q] : 1'b0;
    assign out_err_count = err_cnt_q;

    // Next-state for pointers, occupancy and the saturating illegal-entry counter.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
        if (push && err_new && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Control registers; reset wins over any push or pop at the same edge.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            err_cnt_q <= 16'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Payload slots need no reset: outputs are masked to zero while the FIFO is empty.
    always_ff @(posedge in_clk) begin
        if (push) begin
            imm_q[wr_ptr_q] <= imm_new;
            tag_q[wr_ptr_q] <= in_tag;
            err_q[wr_ptr_q] <= err_new;
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64, output immediate width; legal values 32 and 64 only.
REQ-002 Parameter AUTO_DECODE, default 0; 0 takes the type from in_inst_type, 1 derives it from opcode in_data[6:0].
REQ-003 Parameter TAG_W, default 5, width of the sideband tag (e.g. destination register) carried with each entry.
REQ-004 in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 in_rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream offers an instruction this cycle.
REQ-007 in_data  input  32  instruction word.
REQ-008 in_inst_type  input  3  immediate format; 0=I, 1=S, 2=B, 3=U, 4=J, 7=none, 5/6 illegal; ignored when AUTO_DECODE=1.
REQ-009 in_tag  input  TAG_W  sideband tag.
REQ-010 out_accept  output  1  block can take an entry this cycle.
REQ-011 in_ready  input  1  downstream can take an entry this cycle.
REQ-012 out_valid  output  1  head entry is valid.
REQ-013 out_data  output  XLEN  immediate of the head entry.
REQ-014 out_tag  output  TAG_W  tag of the head entry.
REQ-015 out_err  output  1  head entry had an illegal type or opcode.
REQ-016 out_err_count  output  16  count of accepted illegal entries, saturating.

Function
REQ-017 Push = in_valid & out_accept; pop = out_valid & in_ready; transfers occur at the rising edge.
REQ-018 Storage is a 2-entry FIFO; each entry holds {imm, tag, err}; immediate computed combinationally from the input and written on push.
REQ-019 out_accept = (occupancy != 2), derived from registered occupancy only; no combinational path from in_ready to out_accept.
REQ-020 out_valid = (occupancy != 0); out_data/out_tag/out_err reflect the oldest entry; when occupancy is 0 they are 0.
REQ-021 Latency: entry pushed at edge N is visible on out_valid in the cycle after edge N; sustained throughput 1 entry/cycle when in_ready stays high.
REQ-022 Push and pop in the same edge: occupancy unchanged, order preserved; legal at occupancy 1; at occupancy 0 only push occurs; at occupancy 2 only pop occurs.
REQ-023 Entries leave in push order; a held entry (out_valid & !in_ready) keeps out_data/out_tag/out_err stable.
REQ-024 I = sext(in_data[31:20]).
REQ-025 S = sext({in_data[31:25], in_data[11:7]}).
REQ-026 B = sext({in_data[31], in_data[7], in_data[30:25], in_data[11:8], 1'b0}).
REQ-027 U = sext({in_data[31:12], 12'b0}); bits [11:0] are zero.
REQ-028 J = sext({in_data[31], in_data[19:12], in_data[20], in_data[30:21], 1'b0}).
REQ-029 All sign extension is from in_data[31] to XLEN bits.
REQ-030 Type 7: imm 0, err 0; types 5/6: imm 0, err 1.
REQ-031 AUTO_DECODE=1 opcode map:
- I: 0000011, 0010011, 0011011, 1100111, 1110011
- S: 0100011
- B: 1100011
- U: 0110111, 0010111
- J: 1101111
- none: 0110011, 0111011
- any other opcode: imm 0, err 1
REQ-032 out_err_count increments by 1 on each push with err=1 and holds at 16'hFFFF.

Reset
REQ-033 While in_rst is high at an edge: occupancy 0, FIFO pointers 0, out_err_count 0; in the following cycle out_valid=0, out_data=0, out_tag=0, out_err=0, out_accept=1.
REQ-034 Reset overrides a push or pop at the same edge; in-flight entries are discarded.

Verification
REQ-035 XLEN=64, in_inst_type=0, in_data=32'hFFF00093 pushed, in_ready=1 -> next cycle out_valid=1, out_data=64'hFFFFFFFFFFFFFFFF, out_err=0.
REQ-036 Type 3 with in_data=32'h123450B7 -> out_data=64'h0000000012345000; XLEN=32 with in_data=32'h800000B7 -> out_data=32'h80000000.
REQ-037 Type 2 with in_data=32'hFE000EE3 (offset -4) -> out_data=64'hFFFFFFFFFFFFFFFC; type 4 with in_data=32'h0080006F -> out_data=8.
REQ-038 in_ready=0, push 3 entries back-to-back -> out_accept=0 after the 2nd push and the 3rd is not taken; raise in_ready -> tags emerge in order, out_accept returns to 1 the cycle after the first pop.
REQ-039 AUTO_DECODE=1, in_data opcode 7'b1111111 pushed 3 times -> out_err=1 and out_data=0 per entry, out_err_count=3; preload the count near saturation and push illegal entries -> it holds at 16'hFFFF.
REQ-040 Assert in_rst with occupancy 2 and a simultaneous push -> next cycle out_valid=0, out_err_count=0, out_accept=1.
